// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control unit: FSM states,
// datapath mux codes, opcodes and the illegal-encoding check.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JUMP, S_JALR1, S_UPPER, S_TRAP
  } state_e;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  localparam logic [1:0] ST_B = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_W = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_illegal(input logic [6:0] op, input logic [2:0] f3);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LOAD:   bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      OP_STORE:  bad = (f3 >= 3'b011);
      OP_BRANCH: bad = (f3 == 3'b010) || (f3 == 3'b011);
      OP_JALR:   bad = (f3 != 3'b000);
      OP_R, OP_I, OP_JAL, OP_LUI, OP_AUIPC: bad = 1'b0;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Conditional-branch resolution from the rs1-rs2 compare flags.
// Carry=1 means the subtraction produced no borrow (rs1 >= rs2 unsigned).
module branch_cond (
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       neg_i,
  input  logic       carry_i,
  input  logic       ovf_i,
  output logic       take_o
);

  always_comb begin
    take_o = 1'b0;
    case (funct3_i)
      3'b000:  take_o = zero_i;
      3'b001:  take_o = !zero_i;
      3'b100:  take_o = neg_i ^ ovf_i;
      3'b101:  take_o = !(neg_i ^ ovf_i);
      3'b110:  take_o = !carry_i;
      3'b111:  take_o = carry_i;
      default: take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// RV32I multicycle control unit: Moore sequencer over a shared ALU and a
// single handshaked memory port, with sub-word decode, trapping and instret.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_HS       = 1,
  parameter int ILLEGAL_TRAP = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             Neg,
  input  logic             Carry,
  input  logic             Ovf,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic [2:0]       Load,
  output logic [1:0]       Store,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             ready;
  logic             take;
  logic             illegal_enc;
  ctrl_t            ctrl_c, ctrl;
  logic [2:0]       imm_c, load_c;
  logic [1:0]       store_c;
  logic             unused_f7b5;

  // funct7b5 only matters to the ALU decoder in the datapath.
  assign unused_f7b5 = funct7b5;
  assign ready       = (MEM_HS != 0) ? mem_ready : 1'b1;
  assign illegal_enc = is_illegal(op, funct3);

  branch_cond u_branch_cond (
    .funct3_i (funct3),
    .zero_i   (Zero),
    .neg_i    (Neg),
    .carry_i  (Carry),
    .ovf_i    (Ovf),
    .take_o   (take)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE: begin
        if (illegal_enc) begin
          state_d = (ILLEGAL_TRAP != 0) ? S_TRAP : S_FETCH;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R:              state_d = S_EXECR;
            OP_I:              state_d = S_EXECI;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JUMP;
            OP_JALR:           state_d = S_JALR1;
            OP_LUI, OP_AUIPC:  state_d = S_UPPER;
            default:           state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_ALUWB;
      S_JALR1:    state_d = S_JUMP;
      S_UPPER:    state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Every return to FETCH retires one instruction; TRAP never returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != S_FETCH && state_d == S_FETCH)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    ctrl_c = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_req    = 1'b1;
        ctrl_c.result_src = RES_ALURESULT;
        ctrl_c.alu_src_a  = SRCA_PC;
        ctrl_c.alu_src_b  = SRCB_FOUR;
        ctrl_c.ir_write   = ready;
        ctrl_c.pc_write   = ready;
      end
      S_DECODE: begin
        ctrl_c.alu_src_a = SRCA_OLDPC;
        ctrl_c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR, S_JALR1: begin
        ctrl_c.alu_src_a = SRCA_RS1;
        ctrl_c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl_c.result_src = RES_RDATA;
        ctrl_c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_c.mem_req   = 1'b1;
        ctrl_c.adr_src   = 1'b1;
        ctrl_c.mem_write = 1'b1;
      end
      S_EXECR: begin
        ctrl_c.alu_src_a = SRCA_RS1;
        ctrl_c.alu_src_b = SRCB_RS2;
        ctrl_c.alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        ctrl_c.alu_src_a = SRCA_RS1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a  = SRCA_RS1;
        ctrl_c.alu_src_b  = SRCB_RS2;
        ctrl_c.alu_op     = ALU_SUB;
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.pc_write   = take;
      end
      S_JUMP: begin
        ctrl_c.alu_src_a  = SRCA_OLDPC;
        ctrl_c.alu_src_b  = SRCB_FOUR;
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.pc_write   = 1'b1;
      end
      S_UPPER: begin
        ctrl_c.alu_src_a = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        ctrl_c.alu_src_b = SRCB_IMM;
      end
      default: ctrl_c = '0;
    endcase
  end

  always_comb begin
    imm_c = IMM_I;
    case (op)
      OP_STORE:         imm_c = IMM_S;
      OP_BRANCH:        imm_c = IMM_B;
      OP_JAL:           imm_c = IMM_J;
      OP_LUI, OP_AUIPC: imm_c = IMM_U;
      default:          imm_c = IMM_I;
    endcase
    load_c = LD_B;
    case (funct3)
      3'b001:  load_c = LD_H;
      3'b010:  load_c = LD_W;
      3'b100:  load_c = LD_BU;
      3'b101:  load_c = LD_HU;
      default: load_c = LD_B;
    endcase
    store_c = ST_B;
    case (funct3)
      3'b001:  store_c = ST_H;
      3'b010:  store_c = ST_W;
      default: store_c = ST_B;
    endcase
  end

  // Reset gates outputs combinationally so a pending access drops at once.
  assign ctrl      = reset ? '0 : ctrl_c;
  assign mem_req   = ctrl.mem_req;
  assign AdrSrc    = ctrl.adr_src;
  assign IRWrite   = ctrl.ir_write;
  assign PCWrite   = ctrl.pc_write;
  assign MemWrite  = ctrl.mem_write;
  assign RegWrite  = ctrl.reg_write;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ImmSrc    = reset ? 3'b000 : imm_c;
  assign Load      = reset ? 3'b000 : load_c;
  assign Store     = reset ? 2'b00 : store_c;
  assign illegal   = !reset && (state_q == S_TRAP);
  assign instret   = reset ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle vector bench for multicycle_controller (CNT_W=4 so
// the retirement counter wrap is reachable in a short run).
module tb_multicycle_controller;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
  localparam logic [13:0] K_ZERO   = 14'b0;
  localparam logic [13:0] K_FETCH  = {6'b101100, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [13:0] K_FWAIT  = {6'b100000, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [13:0] K_DECODE = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00};
  localparam logic [13:0] K_MEMADR = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00};
  localparam logic [13:0] K_MEMRD  = {6'b110000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [13:0] K_MEMWB  = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [13:0] K_MEMWR  = {6'b110010, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [13:0] K_EXECR  = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10};
  localparam logic [13:0] K_EXECI  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10};
  localparam logic [13:0] K_ALUWB  = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [13:0] K_BR_T   = {6'b000100, 2'b00, 2'b10, 2'b00, 2'b01};
  localparam logic [13:0] K_BR_N   = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01};
  localparam logic [13:0] K_JUMP   = {6'b000100, 2'b00, 2'b01, 2'b10, 2'b00};
  localparam logic [13:0] K_JALR1  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00};
  localparam logic [13:0] K_LUI    = {6'b000000, 2'b00, 2'b11, 2'b01, 2'b00};
  localparam logic [13:0] K_AUIPC  = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00};

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero, Neg, Carry, Ovf;
  logic       mem_ready;
  logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc, Load;
  logic [1:0] Store;
  logic       illegal;
  logic [3:0] instret;
  logic [13:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_HS(1), .ILLEGAL_TRAP(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .Load(Load), .Store(Store), .illegal(illegal), .instret(instret)
  );

  assign obs = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [3:0]  zncv;
    logic        rdy;
    logic [13:0] ctrl;
    logic        ill;
    logic [3:0]  cnt;
  } vec_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [2:0] imm;
    logic [2:0] ld;
    logic [1:0] st;
  } dec_t;

  vec_t vt[$];
  dec_t dt[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic v(input logic r, input logic [6:0] o, input logic [2:0] f,
                   input logic [3:0] fl, input logic rd, input logic [13:0] c,
                   input logic il, input logic [3:0] cn);
    vt.push_back('{rst: r, op: o, f3: f, zncv: fl, rdy: rd, ctrl: c, ill: il, cnt: cn});
  endtask

  // Drive one cycle's inputs at posedge+1 and land on the following negedge.
  task automatic drive(input logic r, input logic [6:0] o, input logic [2:0] f,
                       input logic [3:0] fl, input logic rd);
    reset = r; op = o; funct3 = f; {Zero, Neg, Carry, Ovf} = fl; mem_ready = rd;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0;
    {Zero, Neg, Carry, Ovf} = 4'b0000; mem_ready = 1'b1;

    // add x3,x1,x2
    v(1, OP_R, 0, 4'b0000, 1, K_ZERO,   0, 0);
    v(0, OP_R, 0, 4'b0000, 1, K_FETCH,  0, 0);
    v(0, OP_R, 0, 4'b0000, 1, K_DECODE, 0, 0);
    v(0, OP_R, 0, 4'b0000, 1, K_EXECR,  0, 0);
    v(0, OP_R, 0, 4'b0000, 1, K_ALUWB,  0, 0);
    // lw with two wait cycles in MEMREAD
    v(0, OP_LOAD, 2, 4'b0000, 1, K_FETCH,  0, 1);
    v(0, OP_LOAD, 2, 4'b0000, 1, K_DECODE, 0, 1);
    v(0, OP_LOAD, 2, 4'b0000, 1, K_MEMADR, 0, 1);
    v(0, OP_LOAD, 2, 4'b0000, 0, K_MEMRD,  0, 1);
    v(0, OP_LOAD, 2, 4'b0000, 0, K_MEMRD,  0, 1);
    v(0, OP_LOAD, 2, 4'b0000, 1, K_MEMRD,  0, 1);
    v(0, OP_LOAD, 2, 4'b0000, 1, K_MEMWB,  0, 1);
    // sh with one wait cycle in MEMWRITE
    v(0, OP_STORE, 1, 4'b0000, 1, K_FETCH,  0, 2);
    v(0, OP_STORE, 1, 4'b0000, 1, K_DECODE, 0, 2);
    v(0, OP_STORE, 1, 4'b0000, 1, K_MEMADR, 0, 2);
    v(0, OP_STORE, 1, 4'b0000, 0, K_MEMWR,  0, 2);
    v(0, OP_STORE, 1, 4'b0000, 1, K_MEMWR,  0, 2);
    // blt N=1 V=0 taken; bltu C=1 not taken; beq Z=1 taken; bge N=1 V=1 taken
    v(0, OP_BRANCH, 4, 4'b0100, 1, K_FETCH,  0, 3);
    v(0, OP_BRANCH, 4, 4'b0100, 1, K_DECODE, 0, 3);
    v(0, OP_BRANCH, 4, 4'b0100, 1, K_BR_T,   0, 3);
    v(0, OP_BRANCH, 6, 4'b0010, 1, K_FETCH,  0, 4);
    v(0, OP_BRANCH, 6, 4'b0010, 1, K_DECODE, 0, 4);
    v(0, OP_BRANCH, 6, 4'b0010, 1, K_BR_N,   0, 4);
    v(0, OP_BRANCH, 0, 4'b1000, 1, K_FETCH,  0, 5);
    v(0, OP_BRANCH, 0, 4'b1000, 1, K_DECODE, 0, 5);
    v(0, OP_BRANCH, 0, 4'b1000, 1, K_BR_T,   0, 5);
    v(0, OP_BRANCH, 5, 4'b0101, 1, K_FETCH,  0, 6);
    v(0, OP_BRANCH, 5, 4'b0101, 1, K_DECODE, 0, 6);
    v(0, OP_BRANCH, 5, 4'b0101, 1, K_BR_T,   0, 6);
    // lui, auipc, addi
    v(0, OP_LUI, 0, 4'b0000, 1, K_FETCH,  0, 7);
    v(0, OP_LUI, 0, 4'b0000, 1, K_DECODE, 0, 7);
    v(0, OP_LUI, 0, 4'b0000, 1, K_LUI,    0, 7);
    v(0, OP_LUI, 0, 4'b0000, 1, K_ALUWB,  0, 7);
    v(0, OP_AUIPC, 0, 4'b0000, 1, K_FETCH,  0, 8);
    v(0, OP_AUIPC, 0, 4'b0000, 1, K_DECODE, 0, 8);
    v(0, OP_AUIPC, 0, 4'b0000, 1, K_AUIPC,  0, 8);
    v(0, OP_AUIPC, 0, 4'b0000, 1, K_ALUWB,  0, 8);
    v(0, OP_I, 0, 4'b0000, 1, K_FETCH,  0, 9);
    v(0, OP_I, 0, 4'b0000, 1, K_DECODE, 0, 9);
    v(0, OP_I, 0, 4'b0000, 1, K_EXECI,  0, 9);
    v(0, OP_I, 0, 4'b0000, 1, K_ALUWB,  0, 9);
    // jal, jalr
    v(0, OP_JAL, 0, 4'b0000, 1, K_FETCH,  0, 10);
    v(0, OP_JAL, 0, 4'b0000, 1, K_DECODE, 0, 10);
    v(0, OP_JAL, 0, 4'b0000, 1, K_JUMP,   0, 10);
    v(0, OP_JAL, 0, 4'b0000, 1, K_ALUWB,  0, 10);
    v(0, OP_JALR, 0, 4'b0000, 1, K_FETCH,  0, 11);
    v(0, OP_JALR, 0, 4'b0000, 1, K_DECODE, 0, 11);
    v(0, OP_JALR, 0, 4'b0000, 1, K_JALR1,  0, 11);
    v(0, OP_JALR, 0, 4'b0000, 1, K_JUMP,   0, 11);
    v(0, OP_JALR, 0, 4'b0000, 1, K_ALUWB,  0, 11);
    // unlisted opcode traps, counter frozen; reset clears
    v(0, OP_BAD, 0, 4'b0000, 1, K_FETCH,  0, 12);
    v(0, OP_BAD, 0, 4'b0000, 1, K_DECODE, 0, 12);
    v(0, OP_BAD, 0, 4'b0000, 1, K_ZERO,   1, 12);
    v(0, OP_BAD, 0, 4'b0000, 1, K_ZERO,   1, 12);
    v(1, OP_BAD, 0, 4'b0000, 1, K_ZERO,   0, 0);
    // jalr with funct3=001 is illegal
    v(0, OP_JALR, 1, 4'b0000, 1, K_FETCH,  0, 0);
    v(0, OP_JALR, 1, 4'b0000, 1, K_DECODE, 0, 0);
    v(0, OP_JALR, 1, 4'b0000, 1, K_ZERO,   1, 0);
    v(1, OP_JALR, 1, 4'b0000, 1, K_ZERO,   0, 0);

    tick();
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].op, vt[i].f3, vt[i].zncv, vt[i].rdy);
      $display("vec %0d rst=%0b op=%b f3=%0d rdy=%0b ctrl=%b ill=%0b cnt=%0d",
               i, vt[i].rst, vt[i].op, vt[i].f3, vt[i].rdy, obs, illegal, instret);
      chk($sformatf("ctrl vec%0d", i),    16'(obs),     16'(vt[i].ctrl));
      chk($sformatf("illegal vec%0d", i), 16'(illegal), 16'(vt[i].ill));
      chk($sformatf("instret vec%0d", i), 16'(instret), 16'(vt[i].cnt));
      tick();
    end

    // Sub-word / immediate decode, observed while FETCH waits for memory.
    dt.push_back('{op: OP_LOAD,   f3: 3'd0, imm: 3'b000, ld: 3'b000, st: 2'b00});
    dt.push_back('{op: OP_LOAD,   f3: 3'd1, imm: 3'b000, ld: 3'b001, st: 2'b01});
    dt.push_back('{op: OP_LOAD,   f3: 3'd2, imm: 3'b000, ld: 3'b010, st: 2'b10});
    dt.push_back('{op: OP_LOAD,   f3: 3'd4, imm: 3'b000, ld: 3'b011, st: 2'b00});
    dt.push_back('{op: OP_LOAD,   f3: 3'd5, imm: 3'b000, ld: 3'b100, st: 2'b00});
    dt.push_back('{op: OP_STORE,  f3: 3'd0, imm: 3'b001, ld: 3'b000, st: 2'b00});
    dt.push_back('{op: OP_STORE,  f3: 3'd1, imm: 3'b001, ld: 3'b001, st: 2'b01});
    dt.push_back('{op: OP_STORE,  f3: 3'd2, imm: 3'b001, ld: 3'b010, st: 2'b10});
    dt.push_back('{op: OP_BRANCH, f3: 3'd0, imm: 3'b010, ld: 3'b000, st: 2'b00});
    dt.push_back('{op: OP_JAL,    f3: 3'd0, imm: 3'b011, ld: 3'b000, st: 2'b00});
    dt.push_back('{op: OP_LUI,    f3: 3'd0, imm: 3'b100, ld: 3'b000, st: 2'b00});
    dt.push_back('{op: OP_AUIPC,  f3: 3'd0, imm: 3'b100, ld: 3'b000, st: 2'b00});
    dt.push_back('{op: OP_JALR,   f3: 3'd0, imm: 3'b000, ld: 3'b000, st: 2'b00});
    drive(1, OP_R, 0, 4'b0000, 1); tick();
    for (int i = 0; i < dt.size(); i++) begin
      drive(0, dt[i].op, dt[i].f3, 4'b0000, 0);
      $display("dec %0d op=%b f3=%0d imm=%b load=%b store=%b",
               i, dt[i].op, dt[i].f3, ImmSrc, Load, Store);
      chk($sformatf("decode %0d", i), 16'({ImmSrc, Load, Store}),
          16'({dt[i].imm, dt[i].ld, dt[i].st}));
      tick();
    end

    // Reset during a FETCH wait drops mem_req in the same cycle, then refetch.
    drive(0, OP_R, 0, 4'b0000, 0);
    chk("fetch wait ctrl", 16'(obs), 16'(K_FWAIT));
    tick();
    drive(1, OP_R, 0, 4'b0000, 0);
    chk("reset in fetch wait mem_req", 16'(mem_req), 16'(0));
    tick();
    drive(0, OP_R, 0, 4'b0000, 1);
    chk("refetch after reset", 16'(obs), 16'(K_FETCH));
    $display("seq reset-in-fetch-wait mem_req/refetch ctrl=%b", obs);
    tick();

    // Reset mid-store: MemWrite drops immediately and the store never retires.
    drive(0, OP_STORE, 2, 4'b0000, 1); tick();
    drive(0, OP_STORE, 2, 4'b0000, 1); tick();
    drive(0, OP_STORE, 2, 4'b0000, 0);
    chk("sw wait ctrl", 16'(obs), 16'(K_MEMWR));
    tick();
    drive(1, OP_STORE, 2, 4'b0000, 0);
    chk("reset mid-store", 16'({mem_req, MemWrite}), 16'(0));
    tick();
    drive(0, OP_STORE, 2, 4'b0000, 0);
    chk("after reset mid-store ctrl", 16'(obs), 16'(K_FWAIT));
    chk("after reset mid-store instret", 16'(instret), 16'(0));
    $display("seq reset-mid-store ctrl=%b instret=%0d", obs, instret);
    tick();

    // Sixteen not-taken beq instructions wrap the 4-bit counter.
    for (int i = 0; i < 16; i++) begin
      drive(0, OP_BRANCH, 0, 4'b0000, 1);
      chk($sformatf("wrap instret %0d", i), 16'(instret), 16'(i));
      tick();
      drive(0, OP_BRANCH, 0, 4'b0000, 1); tick();
      drive(0, OP_BRANCH, 0, 4'b0000, 1);
      chk($sformatf("wrap beq %0d", i), 16'(obs), 16'(K_BR_N));
      tick();
    end
    drive(0, OP_BRANCH, 0, 4'b0000, 0);
    chk("wrap instret final", 16'(instret), 16'(0));
    $display("seq wrap instret=%0d", instret);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
